// File: rtl/parking_pkg.sv
// Shared width helpers and reset values for parking_occupancy_tracker and its slot debouncers.
package parking_pkg;

    function automatic int slot_idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam logic SYNC_RST   = 1'b0;
    localparam logic PARKED_RST = 1'b0;
    localparam logic PULSE_RST  = 1'b0;

endpackage

// File: rtl/slot_debouncer.sv
// One slot: 2-FF synchroniser followed by a counter that accepts a new level only after
// it has differed from the held occupancy for DEBOUNCE_CYCLES consecutive cycles.
module slot_debouncer
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_raw,
    output logic parked_o,
    output logic parked_nxt_o
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          parked_q, parked_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        parked_d = parked_q;
        if (sync2_q == parked_q) begin
            cnt_d = '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            parked_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= SYNC_RST;
            sync2_q  <= SYNC_RST;
            cnt_q    <= '0;
            parked_q <= PARKED_RST;
        end else begin
            sync1_q  <= sensor_raw;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            parked_q <= parked_d;
        end
    end

    assign parked_o     = parked_q;
    assign parked_nxt_o = parked_d;

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Debounced parking occupancy with free-slot count, lowest free slot and arrive/depart events.
// Optional slot reservation is enabled by defining PARKING_RESERVATION_EN.
module parking_occupancy_tracker
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS       = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ARRIVE_CNT_W    = 16,
    localparam int CW = count_w(NUM_SLOTS),
    localparam int IW = slot_idx_w(NUM_SLOTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SLOTS-1:0]    sensor,
    output logic [NUM_SLOTS-1:0]    parked,
    output logic [CW-1:0]           empty_count,
    output logic                    full,
    output logic                    all_empty,
    output logic [IW-1:0]           first_free,
    output logic                    free_valid,
    output logic                    arrive,
    output logic                    depart,
    output logic [ARRIVE_CNT_W-1:0] arrive_total
`ifdef PARKING_RESERVATION_EN
    ,
    input  logic                    res_req,
    output logic                    res_gnt,
    output logic                    res_nack,
    output logic [IW-1:0]           res_slot,
    input  logic                    res_cancel,
    input  logic [IW-1:0]           res_cancel_slot
`endif
);

    logic [NUM_SLOTS-1:0]    parked_q, parked_d, rise, fall, reserved, used;
    logic [CW-1:0]           rise_cnt, occ_cnt;
    logic                    arrive_q, arrive_d, depart_q, depart_d;
    logic [ARRIVE_CNT_W-1:0] total_q, total_d;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        slot_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk          (clk),
            .rst_n        (rst_n),
            .sensor_raw   (sensor[g]),
            .parked_o     (parked_q[g]),
            .parked_nxt_o (parked_d[g])
        );
    end

    assign rise = parked_d & ~parked_q;
    assign fall = parked_q & ~parked_d;

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) rise_cnt = rise_cnt + CW'(rise[i]);
        arrive_d = |rise;
        depart_d = |fall;
        total_d  = total_q + ARRIVE_CNT_W'(rise_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arrive_q <= PULSE_RST;
            depart_q <= PULSE_RST;
            total_q  <= '0;
        end else begin
            arrive_q <= arrive_d;
            depart_q <= depart_d;
            total_q  <= total_d;
        end
    end

`ifdef PARKING_RESERVATION_EN
    // res_req is sampled every edge with no back-pressure; each sampled request yields exactly
    // one single-cycle res_gnt (with res_slot) or res_nack on the following cycle.
    logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
    logic                 gnt_q, gnt_d, nack_q, nack_d, pick_ok;
    logic [IW-1:0]        slot_q, slot_d, pick;

    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!parked_d[i] && !reserved_q[i]) begin
                pick    = IW'(i);
                pick_ok = 1'b1;
            end
        end
        reserved_d = reserved_q & ~rise;
        if (res_cancel && (int'(res_cancel_slot) < NUM_SLOTS)) reserved_d[res_cancel_slot] = 1'b0;
        gnt_d  = res_req && pick_ok;
        nack_d = res_req && !pick_ok;
        slot_d = slot_q;
        // Grant is applied last so it overrides a same-edge cancel of the same slot.
        if (gnt_d) begin
            reserved_d[pick] = 1'b1;
            slot_d           = pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reserved_q <= '0;
            gnt_q      <= PULSE_RST;
            nack_q     <= PULSE_RST;
            slot_q     <= '0;
        end else begin
            reserved_q <= reserved_d;
            gnt_q      <= gnt_d;
            nack_q     <= nack_d;
            slot_q     <= slot_d;
        end
    end

    assign reserved = reserved_q;
    assign res_gnt  = gnt_q;
    assign res_nack = nack_q;
    assign res_slot = slot_q;
`else
    assign reserved = '0;
`endif

    always_comb begin
        used       = parked_q | reserved;
        occ_cnt    = '0;
        first_free = '0;
        for (int i = 0; i < NUM_SLOTS; i++) occ_cnt = occ_cnt + CW'(used[i]);
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!used[i]) first_free = IW'(i);
        end
        empty_count = CW'(NUM_SLOTS) - occ_cnt;
        full        = (empty_count == '0);
        free_valid  = !full;
        all_empty   = (parked_q == '0);
    end

    assign parked       = parked_q;
    assign arrive       = arrive_q;
    assign depart       = depart_q;
    assign arrive_total = total_q;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Directed plus randomized bench for parking_occupancy_tracker against a sample-history model.
module tb_parking_occupancy_tracker;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int AW = 16;
  localparam int CW = 4;
  localparam int IW = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  sensor;
  logic [N-1:0]  parked;
  logic [CW-1:0] empty_count;
  logic          full, all_empty, free_valid, arrive, depart;
  logic [IW-1:0] first_free;
  logic [AW-1:0] arrive_total;
  logic          res_req, res_gnt, res_nack, res_cancel;
  logic [IW-1:0] res_slot, res_cancel_slot;

  int total;
  int bad;

  logic [N-1:0]  hist[$];
  logic [N-1:0]  m_parked, m_res;
  logic          m_arrive, m_depart, m_gnt, m_nack;
  logic [AW-1:0] m_total;
  logic [IW-1:0] m_slot;

  parking_occupancy_tracker #(.NUM_SLOTS(N), .DEBOUNCE_CYCLES(D), .ARRIVE_CNT_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sensor          (sensor),
    .parked          (parked),
    .empty_count     (empty_count),
    .full            (full),
    .all_empty       (all_empty),
    .first_free      (first_free),
    .free_valid      (free_valid),
    .arrive          (arrive),
    .depart          (depart),
    .arrive_total    (arrive_total)
`ifdef PARKING_RESERVATION_EN
    ,
    .res_req         (res_req),
    .res_gnt         (res_gnt),
    .res_nack        (res_nack),
    .res_slot        (res_slot),
    .res_cancel      (res_cancel),
    .res_cancel_slot (res_cancel_slot)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a slot flips when its last D synchronised samples all disagree with it
  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < D + 2; i++) hist.push_back('0);
    m_parked = '0;
    m_res    = '0;
    m_arrive = 1'b0;
    m_depart = 1'b0;
    m_gnt    = 1'b0;
    m_nack   = 1'b0;
    m_total  = '0;
    m_slot   = '0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] np, rise, nres;
    int sz, pick;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(sensor);
    sz = hist.size();
    np = m_parked;
    for (int s = 0; s < N; s++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (hist[sz-3-j][s] == m_parked[s]) all_diff = 1'b0;
      if (all_diff) np[s] = ~m_parked[s];
    end
    while (hist.size() > D + 2) void'(hist.pop_front());
    rise     = np & ~m_parked;
    m_arrive = |rise;
    m_depart = |(m_parked & ~np);
    m_total  = m_total + AW'($countones(rise));
    nres     = m_res & ~rise;
    m_gnt    = 1'b0;
    m_nack   = 1'b0;
`ifdef PARKING_RESERVATION_EN
    if (res_cancel) nres[res_cancel_slot] = 1'b0;
    if (res_req) begin
      pick = -1;
      for (int s = N - 1; s >= 0; s--) if (!np[s] && !m_res[s]) pick = s;
      if (pick >= 0) begin
        nres[pick] = 1'b1;
        m_gnt      = 1'b1;
        m_slot     = IW'(pick);
      end else begin
        m_nack = 1'b1;
      end
    end
`endif
    m_res    = nres;
    m_parked = np;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] used;
    int ff;
    used = m_parked | m_res;
    ff = 0;
    for (int s = N - 1; s >= 0; s--) if (!used[s]) ff = s;
    chk({tag, ".parked"},       32'(parked),       32'(m_parked));
    chk({tag, ".empty_count"},  32'(empty_count),  32'(N - $countones(used)));
    chk({tag, ".full"},         32'(full),         32'(used == '1));
    chk({tag, ".all_empty"},    32'(all_empty),    32'(m_parked == '0));
    chk({tag, ".first_free"},   32'(first_free),   32'((used == '1) ? 0 : ff));
    chk({tag, ".free_valid"},   32'(free_valid),   32'(used != '1));
    chk({tag, ".arrive"},       32'(arrive),       32'(m_arrive));
    chk({tag, ".depart"},       32'(depart),       32'(m_depart));
    chk({tag, ".arrive_total"}, 32'(arrive_total), 32'(m_total));
`ifdef PARKING_RESERVATION_EN
    chk({tag, ".res_gnt"},      32'(res_gnt),      32'(m_gnt));
    chk({tag, ".res_nack"},     32'(res_nack),     32'(m_nack));
    if (m_gnt) chk({tag, ".res_slot"}, 32'(res_slot), 32'(m_slot));
`endif
  endtask

  // driver: one rising edge, model update, then sample 1 time unit later
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    sensor = '0;
    res_req = 1'b0;
    res_cancel = 1'b0;
    res_cancel_slot = '0;
    model_reset();

    // 1: reset values
    #12;
    check_all("reset");
    chk("reset.empty_const", 32'(empty_count), 32'd8);
    chk("reset.all_empty_const", 32'(all_empty), 32'd1);
    chk("reset.free_valid_const", 32'(free_valid), 32'd1);
    chk("reset.first_free_const", 32'(first_free), 32'd0);
    rst_n = 1'b1;

    // 2: single arrival, exact D+2 latency
    sensor = 8'h08;
    steps("arr3", 5);
    chk("arr3.before_edge6", 32'(parked), 32'h00);
    step("arr3");
    chk("arr3.edge6_parked", 32'(parked), 32'h08);
    chk("arr3.edge6_arrive", 32'(arrive), 32'd1);
    chk("arr3.edge6_total", 32'(arrive_total), 32'd1);
    chk("arr3.edge6_empty", 32'(empty_count), 32'd7);
    step("arr3");
    chk("arr3.pulse_end", 32'(arrive), 32'd0);

    // 3: short glitch on slot 5
    sensor = 8'h28;
    steps("glitch5", 3);
    sensor = 8'h08;
    steps("glitch5", 8);
    chk("glitch5.parked_const", 32'(parked), 32'h08);

    // 4: all slots, then slot 0 leaves
    sensor = 8'h00;
    steps("clear", 8);
    sensor = 8'hFF;
    steps("fill", 8);
    chk("fill.full_const", 32'(full), 32'd1);
    chk("fill.free_valid_const", 32'(free_valid), 32'd0);
    chk("fill.empty_const", 32'(empty_count), 32'd0);
    chk("fill.total_const", 32'(arrive_total), 32'd9);
    sensor = 8'hFE;
    steps("leave0", 5);
    step("leave0");
    chk("leave0.depart_const", 32'(depart), 32'd1);
    chk("leave0.first_free_const", 32'(first_free), 32'd0);
    chk("leave0.empty_const", 32'(empty_count), 32'd1);

    // 5: reset in the middle of a slot 2 debounce
    sensor = 8'h00;
    steps("settle", 8);
    sensor = 8'h04;
    steps("mid2", 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    chk("rst_mid.empty_const", 32'(empty_count), 32'd8);
    steps("in_rst", 2);
    rst_n = 1'b1;
    steps("post_rst", 5);
    chk("post_rst.before_edge6", 32'(parked), 32'h00);
    step("post_rst");
    chk("post_rst.edge6", 32'(parked), 32'h04);

    // randomized phase
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) sensor[$urandom_range(0, N - 1)] ^= 1'b1;
`ifdef PARKING_RESERVATION_EN
      res_req = ($urandom_range(0, 5) == 0);
      res_cancel = ($urandom_range(0, 5) == 0);
      res_cancel_slot = IW'($urandom_range(0, N - 1));
`endif
      step("rand");
    end
    res_req = 1'b0;
    res_cancel = 1'b0;

`ifdef PARKING_RESERVATION_EN
    // 6: reservation grant, clear on arrival, nack when full
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    sensor = 8'h03;
    steps("res_park01", 8);
    chk("res.empty_before", 32'(empty_count), 32'd6);
    res_req = 1'b1;
    step("res_grant");
    res_req = 1'b0;
    chk("res.gnt_const", 32'(res_gnt), 32'd1);
    chk("res.slot_const", 32'(res_slot), 32'd2);
    chk("res.empty_after", 32'(empty_count), 32'd5);
    sensor = 8'h07;
    steps("res_arrive2", 8);
    chk("res.empty_arrive2", 32'(empty_count), 32'd5);
    sensor = 8'hFF;
    steps("res_fill", 8);
    res_req = 1'b1;
    step("res_nack");
    res_req = 1'b0;
    chk("res.nack_const", 32'(res_nack), 32'd1);
    step("res_idle");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
